gf_inverse: RTL and testbench

GF_INVERSE -- requirements
Module: gf_inverse

---
 rtl/gf_inverse_pkg.sv | 27 ++
 rtl/gf_inverse_if.sv | 30 +++
 rtl/gf_inverse_mul_comb.sv | 27 ++
 rtl/gf_inverse.sv | 114 +++++++++++
 tb/tb_gf_inverse.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gf_inverse_pkg.sv
// Shared types and constants for the GF(2^8) inverter (package gf_pkg).
// Holds the field width, default reduction polynomial, FSM state type and step counts.
package gf_pkg;

  localparam int unsigned GF_WIDTH    = 8;
  localparam int unsigned SQR_STEPS   = 7;
  localparam int unsigned MUL_STEPS   = 6;
  localparam int unsigned TOTAL_STEPS = SQR_STEPS + MUL_STEPS;
  localparam int unsigned STEP_W      = $clog2(TOTAL_STEPS);

  typedef logic [GF_WIDTH-1:0] gf_elem_t;
  typedef logic [STEP_W-1:0]   step_t;

  // Low byte of x^8+x^4+x^3+x+1
  localparam gf_elem_t GF_POLY_DEFAULT = 8'h1B;

  // Index of the final multiply in the square-and-multiply chain
  localparam step_t LAST_STEP = step_t'(TOTAL_STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQR  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } gf_state_t;

endpackage

// File: rtl/gf_inverse_if.sv
// Operand/result handshake bundle for gf_inverse.
// The slave modport is the inverter side; master is the producer/consumer side.
interface gf_inverse_if;

  logic              in_valid;
  logic              in_ready;
  gf_pkg::gf_elem_t  in_data;
  logic              out_valid;
  logic              out_ready;
  gf_pkg::gf_elem_t  out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/gf_inverse_mul_comb.sv
// Purely combinational GF(2^8) multiplier: shift-and-add with per-shift reduction.
// Every intermediate stays GF_WIDTH bits; overflow out of bit 7 folds POLY back in.
module gf_mul_comb
  import gf_pkg::*;
#(
  parameter gf_elem_t POLY = GF_POLY_DEFAULT
) (
  input  gf_elem_t a,
  input  gf_elem_t b,
  output gf_elem_t p
);

  function automatic gf_elem_t gf_mul(input gf_elem_t x, input gf_elem_t y);
    gf_elem_t prod;
    gf_elem_t sh;
    prod = '0;
    sh   = x;
    for (int i = 0; i < int'(GF_WIDTH); i++) begin
      if (y[i]) prod = prod ^ sh;
      sh = {sh[GF_WIDTH-2:0], 1'b0} ^ (sh[GF_WIDTH-1] ? POLY : gf_elem_t'(0));
    end
    return prod;
  endfunction

  assign p = gf_mul(a, b);

endmodule

// File: rtl/gf_inverse.sv
// GF(2^8) multiplicative inverse via a^254 using one shared multiplier over 13 cycles.
// Optional GF_INV_FASTPATH_EN: operands 0x00/0x01 skip the chain and go straight to DONE.
module gf_inverse
  import gf_pkg::*;
#(
  parameter gf_elem_t POLY = GF_POLY_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  gf_inverse_if.slave  bus
);

  gf_state_t state, state_nxt;
  gf_elem_t  base, base_nxt;
  gf_elem_t  acc, acc_nxt;
  step_t     step, step_nxt;
  logic      out_valid, out_valid_nxt;
  gf_elem_t  out_data, out_data_nxt;

  gf_elem_t  mul_a, mul_b, mul_p;

  gf_mul_comb #(.POLY(POLY)) u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      base      <= '0;
      acc       <= '0;
      step      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nxt;
      base      <= base_nxt;
      acc       <= acc_nxt;
      step      <= step_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
    end
  end

  // Next-state, datapath and multiplier operand selection
  always_comb begin
    state_nxt     = state;
    base_nxt      = base;
    acc_nxt       = acc;
    step_nxt      = step;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    mul_a         = base;
    mul_b         = base;

    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          base_nxt  = bus.in_data;
          step_nxt  = '0;
          state_nxt = SQR;
`ifdef GF_INV_FASTPATH_EN
          // 0 and 1 are their own a^254
          if (bus.in_data[GF_WIDTH-1:1] == '0) begin
            acc_nxt   = bus.in_data;
            state_nxt = DONE;
          end
`endif
        end
      end

      SQR: begin
        mul_a    = base;
        mul_b    = base;
        base_nxt = mul_p;
        step_nxt = step + step_t'(1);
        if (step == '0) begin
          acc_nxt   = mul_p;
          state_nxt = SQR;
        end else begin
          state_nxt = MUL;
        end
      end

      MUL: begin
        mul_a    = acc;
        mul_b    = base;
        acc_nxt  = mul_p;
        step_nxt = step + step_t'(1);
        state_nxt = (step == LAST_STEP) ? DONE : SQR;
      end

      DONE: begin
        // Result is published one edge after entering DONE and held until taken
        if (out_valid && bus.out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end else begin
          out_valid_nxt = 1'b1;
          out_data_nxt  = acc;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;

endmodule

// File: tb/tb_gf_inverse.sv
// Self-checking bench for gf_inverse: vector table, hold/abort sequences and a
// shuffled sweep of all 256 operands against a brute-force inverse table.
module tb_gf_inverse;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  gf_inverse_if bus ();

  gf_inverse #(.POLY(8'h1B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef GF_INV_FASTPATH_EN
  localparam int TRIVIAL_LAT = 1;
`else
  localparam int TRIVIAL_LAT = 14;
`endif
  localparam int FULL_LAT = 14;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] inv_tab [256];

  typedef struct {
    logic [7:0] a;
    logic [7:0] expd;
    int         lat;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expd);
    n_checks++;
    if (act !== expd) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expd);
    end
  endtask

  // Polynomial product then long-division reduction by x^8+x^4+x^3+x+1
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  task automatic run_op(input logic [7:0] a, input logic rdy,
                        output logic [7:0] got, output int lat);
    int w;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("accept_timeout", 32'(w >= 40), 32'd0);
    bus.in_valid  = 1'b1;
    bus.in_data   = a;
    bus.out_ready = rdy;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    check("busy_in_ready", 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    got = bus.out_data;
    if (rdy) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got;
    int         lat;
    int         seen;
    logic [7:0] ops [256];
    logic [7:0] sb [$];

    // Brute-force inverse table from the reference multiply
    inv_tab[0] = 8'h00;
    for (int a = 1; a < 256; a++) begin
      inv_tab[a] = 8'h00;
      for (int x = 1; x < 256; x++)
        if (ref_mul(8'(a), 8'(x)) == 8'h01) inv_tab[a] = 8'(x);
    end

    vecs[0] = '{8'h53, 8'hCA, FULL_LAT};
    vecs[1] = '{8'h02, 8'h8D, FULL_LAT};
    vecs[2] = '{8'hCA, 8'h53, FULL_LAT};
    vecs[3] = '{8'hFF, 8'h1C, FULL_LAT};
    vecs[4] = '{8'h00, 8'h00, TRIVIAL_LAT};
    vecs[5] = '{8'h01, 8'h01, TRIVIAL_LAT};

    // Reset, with in_valid asserted while held low
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h53;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'h00);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    check("rst_no_capture", 32'(seen), 32'd0);

    // Vector table with out_ready held high
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, 1'b1, got, lat);
      check($sformatf("vec%0d_data", i), 32'(got), 32'(vecs[i].expd));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_idle", i), 32'({bus.in_ready, bus.out_valid}), 32'b10);
    end

    // Back-pressure in DONE with stray in_valid pulses carrying 0x07
    run_op(8'h53, 1'b0, got, lat);
    check("hold_lat", 32'(lat), 32'(FULL_LAT));
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = ~i[0];
      bus.in_data  = 8'h07;
      @(posedge clk);
      @(negedge clk);
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_out_data", 32'(bus.out_data), 32'hCA);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("hold_release", 32'({bus.in_ready, bus.out_valid}), 32'b10);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    check("hold_no_capture", 32'(seen), 32'd0);

    // Reset during step 6 of operand 0x53
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h53;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_rst_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_idle", 32'(bus.in_ready), 32'd1);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    check("abort_no_out_valid", 32'(seen), 32'd0);
    run_op(8'h02, 1'b1, got, lat);
    check("abort_next_data", 32'(got), 32'h8D);
    check("abort_next_lat", 32'(lat), 32'(FULL_LAT));

    // All 256 operands, shuffled, with random out_ready
    for (int i = 0; i < 256; i++) ops[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      int j;
      logic [7:0] t;
      j = int'($urandom_range(i, 0));
      t = ops[i];
      ops[i] = ops[j];
      ops[j] = t;
    end
    for (int idx = 0; idx < 256; idx++) begin
      int  w;
      logic done;
      logic [7:0] a_exp;
      w = 0;
      while (bus.in_ready !== 1'b1 && w < 40) begin
        bus.out_ready = 1'($urandom);
        @(negedge clk);
        w++;
      end
      bus.in_valid  = 1'b1;
      bus.in_data   = ops[idx];
      bus.out_ready = 1'($urandom);
      sb.push_back(ops[idx]);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      done = 1'b0;
      w = 0;
      while (!done && w < 80) begin
        bus.out_ready = 1'($urandom);
        if (bus.out_valid === 1'b1 && bus.out_ready) begin
          a_exp = sb.pop_front();
          got   = bus.out_data;
          check($sformatf("sweep_inv_%02h", a_exp), 32'(got), 32'(inv_tab[a_exp]));
          if (a_exp != 8'h00)
            check($sformatf("sweep_prod_%02h", a_exp), 32'(ref_mul(got, a_exp)), 32'h01);
          done = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        w++;
      end
      check($sformatf("sweep_done_%02h", ops[idx]), 32'(done), 32'd1);
    end
    bus.out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
